// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 serial receiver with synchronizer, mid-bit sampling and a one-entry valid/ready holding register.
module uart_rx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_frame_err,
  output logic       o_overrun,
  output logic       o_busy
);

  localparam int HALF = (CLKS_PER_BIT - 1) / 2;
  localparam int TW   = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF_LAST = TW'((HALF > 0) ? HALF - 1 : 0);

  typedef enum logic [2:0] {
    S_WAIT_HIGH,
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t                 r_state;
  logic [SYNC_STAGES-1:0] r_sync;
  logic [TW-1:0]          r_timer;
  logic [2:0]             r_idx;
  logic [7:0]             r_shift;
  logic [7:0]             r_data;
  logic                   r_valid;
  logic                   r_ferr;
  logic                   r_ovr;
  logic                   r_busy;

  state_t        w_state_nx;
  logic [TW-1:0] w_timer_nx;
  logic [2:0]    w_idx_nx;
  logic [7:0]    w_shift_nx;
  logic          w_load;
  logic          w_ferr;
  logic          w_rxs;

  assign w_rxs = r_sync[SYNC_STAGES-1];

  always_comb begin
    w_state_nx = r_state;
    w_timer_nx = r_timer;
    w_idx_nx   = r_idx;
    w_shift_nx = r_shift;
    w_load     = 1'b0;
    w_ferr     = 1'b0;
    case (r_state)
      S_WAIT_HIGH: begin
        if (w_rxs) w_state_nx = S_IDLE;
      end
      S_IDLE: begin
        if (!w_rxs) begin
          // With HALF=0 the detection edge itself is the start-bit sample.
          if (HALF == 0) begin
            w_state_nx = S_DATA;
            w_timer_nx = BIT_LAST;
            w_idx_nx   = 3'd0;
          end else begin
            w_state_nx = S_START;
            w_timer_nx = HALF_LAST;
          end
        end
      end
      S_START: begin
        if (r_timer == '0) begin
          if (!w_rxs) begin
            w_state_nx = S_DATA;
            w_timer_nx = BIT_LAST;
            w_idx_nx   = 3'd0;
          end else begin
            w_state_nx = S_IDLE;
          end
        end else begin
          w_timer_nx = r_timer - TW'(1);
        end
      end
      S_DATA: begin
        if (r_timer == '0) begin
          w_shift_nx[r_idx] = w_rxs;
          w_timer_nx        = BIT_LAST;
          if (r_idx == 3'd7) w_state_nx = S_STOP;
          else               w_idx_nx   = r_idx + 3'd1;
        end else begin
          w_timer_nx = r_timer - TW'(1);
        end
      end
      S_STOP: begin
        if (r_timer == '0) begin
          if (w_rxs) begin
            w_load     = 1'b1;
            w_state_nx = S_IDLE;
          end else begin
            w_ferr     = 1'b1;
            w_state_nx = S_WAIT_HIGH;
          end
        end else begin
          w_timer_nx = r_timer - TW'(1);
        end
      end
      default: w_state_nx = S_WAIT_HIGH;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_WAIT_HIGH;
      r_sync  <= '0;
      r_timer <= '0;
      r_idx   <= 3'd0;
      r_shift <= 8'h00;
      r_data  <= 8'h00;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
      r_busy  <= 1'b1;
    end else begin
      r_sync[0] <= i_rx;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_state <= w_state_nx;
      r_timer <= w_timer_nx;
      r_idx   <= w_idx_nx;
      r_shift <= w_shift_nx;
      r_busy  <= (w_state_nx != S_IDLE);
      r_ferr  <= w_ferr;
      r_ovr   <= w_load & r_valid & ~i_ready;
      // A fresh byte wins over a same-edge consume, so valid stays high.
      if (w_load) begin
        r_data  <= r_shift;
        r_valid <= 1'b1;
      end else if (r_valid && i_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_data      = r_data;
  assign o_valid     = r_valid;
  assign o_frame_err = r_ferr;
  assign o_overrun   = r_ovr;
  assign o_busy      = r_busy;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard bench for uart_rx at CLKS_PER_BIT=1 and 16.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst1, rst16;
  logic       rx1, rx16;
  logic       rdy1, rdy16;
  logic [7:0] d1, d16;
  logic       v1, v16, fe1, fe16, ov1, ov16, b1, b16;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int fe1cnt = 0, ov1cnt = 0, fe16cnt = 0, ov16cnt = 0;
  logic [7:0] q1[$];
  logic [7:0] q16[$];
  int acc1[$];
  int acc16[$];
  int t0, t1, t2;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx #(.CLKS_PER_BIT(1), .SYNC_STAGES(2)) u_dut1 (
    .i_clk(clk), .i_rst(rst1), .i_rx(rx1), .o_data(d1), .o_valid(v1),
    .i_ready(rdy1), .o_frame_err(fe1), .o_overrun(ov1), .o_busy(b1)
  );

  uart_rx #(.CLKS_PER_BIT(16), .SYNC_STAGES(2)) u_dut16 (
    .i_clk(clk), .i_rst(rst16), .i_rx(rx16), .o_data(d16), .o_valid(v16),
    .i_ready(rdy16), .o_frame_err(fe16), .o_overrun(ov16), .o_busy(b16)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives one frame on the 16-clock line; t returns the edge count when the start bit began.
  task automatic send16(input logic [7:0] b, input logic stop_bit, output int t);
    t = cyc;
    rx16 = 1'b0;
    tick(16);
    for (int i = 0; i < 8; i++) begin
      rx16 = b[i];
      tick(16);
    end
    rx16 = stop_bit;
    tick(16);
  endtask

  always @(negedge clk) begin
    if (!rst1) begin
      if (fe1) fe1cnt++;
      if (ov1) ov1cnt++;
      if (v1 && rdy1) begin
        acc1.push_back(cyc + 1);
        if (q1.size() == 0) chk("d1_unexpected_valid", {24'h0, d1}, 32'hFFFF_FFFF);
        else chk("d1_data", {24'h0, d1}, {24'h0, q1.pop_front()});
      end
    end
  end

  always @(negedge clk) begin
    if (!rst16) begin
      if (fe16) fe16cnt++;
      if (ov16) ov16cnt++;
      if (v16 && rdy16) begin
        acc16.push_back(cyc + 1);
        if (q16.size() == 0) chk("d16_unexpected_valid", {24'h0, d16}, 32'hFFFF_FFFF);
        else chk("d16_data", {24'h0, d16}, {24'h0, q16.pop_front()});
      end
    end
  end

  initial begin
    rst1 = 1'b1; rst16 = 1'b1;
    rx1 = 1'b1;  rx16 = 1'b1;
    rdy1 = 1'b1; rdy16 = 1'b1;
    tick(3);
    chk("rst_valid1", v1, 0);
    chk("rst_busy1", b1, 1);
    chk("rst_data1", d1, 0);
    chk("rst_valid16", v16, 0);
    chk("rst_busy16", b16, 1);
    chk("rst_ferr16", fe16, 0);
    rst1 = 1'b0; rst16 = 1'b0;
    tick(5);
    chk("idle_busy16", b16, 0);

    // CLKS_PER_BIT=1: 0x55 with 4 stop bits
    q1.push_back(8'h55);
    t0 = cyc;
    rx1 = 1'b0;
    tick(1);
    for (int i = 0; i < 8; i++) begin
      rx1 = (8'h55 >> i) & 1;
      tick(1);
    end
    rx1 = 1'b1;
    tick(4);
    tick(6);
    chk("c1_accept_count", acc1.size(), 1);
    if (acc1.size() > 0) chk("c1_accept_edge", acc1[0], t0 + 13);
    chk("c1_valid_low", v1, 0);
    chk("c1_no_err", fe1cnt + ov1cnt, 0);

    // CLKS_PER_BIT=16: back-to-back A3, 00, FF
    acc16.delete();
    q16.push_back(8'hA3); q16.push_back(8'h00); q16.push_back(8'hFF);
    send16(8'hA3, 1'b1, t0);
    send16(8'h00, 1'b1, t1);
    send16(8'hFF, 1'b1, t2);
    tick(10);
    chk("b2b_count", acc16.size(), 3);
    if (acc16.size() == 3) begin
      chk("b2b_first_edge", acc16[0], t0 + 155);
      chk("b2b_gap1", acc16[1] - acc16[0], 160);
      chk("b2b_gap2", acc16[2] - acc16[1], 160);
    end

    // Glitch: 5 low cycles
    rx16 = 1'b0;
    tick(5);
    rx16 = 1'b1;
    tick(30);
    chk("glitch_busy", b16, 0);
    chk("glitch_ferr", fe16cnt, 0);
    chk("glitch_valid", v16, 0);

    // Framing error on 0x3C, line held low 40 cycles
    send16(8'h3C, 1'b0, t0);
    tick(24);
    chk("fe_count", fe16cnt, 1);
    chk("fe_valid", v16, 0);
    chk("fe_busy_low_line", b16, 1);
    rx16 = 1'b1;
    tick(4);
    chk("fe_busy_after_high", b16, 0);
    q16.push_back(8'h81);
    send16(8'h81, 1'b1, t0);
    tick(10);
    chk("fe_recover_q", q16.size(), 0);

    // Overrun with ready low
    rdy16 = 1'b0;
    send16(8'h11, 1'b1, t0);
    q16.push_back(8'h22);
    send16(8'h22, 1'b1, t1);
    tick(2);
    chk("ovr_count", ov16cnt, 1);
    chk("ovr_data", d16, 8'h22);
    chk("ovr_valid", v16, 1);
    rdy16 = 1'b1;
    tick(1);
    rdy16 = 1'b0;
    chk("ovr_valid_clear", v16, 0);
    chk("ovr_q", q16.size(), 0);
    rdy16 = 1'b1;

    // Reset during data bit 4 of 0xF0, released with line low
    rx16 = 1'b0;
    tick(16);
    for (int i = 0; i < 4; i++) begin
      rx16 = (8'hF0 >> i) & 1;
      tick(16);
    end
    rx16 = 1'b1;
    tick(8);
    rst16 = 1'b1;
    tick(3);
    rx16 = 1'b0;
    tick(1);
    rst16 = 1'b0;
    tick(30);
    chk("rstmid_busy_low_line", b16, 1);
    chk("rstmid_valid", v16, 0);
    rx16 = 1'b1;
    tick(2);
    chk("rstmid_busy_s", b16, 1);
    tick(1);
    chk("rstmid_busy_s1", b16, 0);
    q16.push_back(8'h5A);
    send16(8'h5A, 1'b1, t0);
    tick(10);

    chk("final_q16", q16.size(), 0);
    chk("final_q1", q1.size(), 0);
    chk("final_ferr16", fe16cnt, 1);
    chk("final_ovr16", ov16cnt, 1);
    chk("final_d1_err", fe1cnt + ov1cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, errors);
    $finish;
  end

endmodule
